// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU FSM states and the legality rule.
package rv32i_pkg;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StErr
    } lsu_state_e;

    // True for an undefined funct3 or an access not aligned to its own size.
    function automatic logic lsu_illegal(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad_code;
        logic misaligned;
        if (is_store) begin
            bad_code = (funct3 >= 3'b011);
        end else begin
            bad_code = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        return bad_code || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-oriented data memory bus: request/grant handshake followed by a read-valid response.
interface load_store_unit_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store byte enables/replication and load extraction.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    assign half     = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign byte_sel = addr_lo[0] ? half[15:8] : half[7:0];

    always_comb begin
        be        = 4'b1111;
        mem_wdata = store_data;
        load_data = mem_rdata;
        if (is_store) begin
            case (funct3)
                Funct3Sb: begin
                    be        = 4'b0001 << addr_lo;
                    mem_wdata = {4{store_data[7:0]}};
                end
                Funct3Sh: begin
                    be        = 4'b0011 << {addr_lo[1], 1'b0};
                    mem_wdata = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end else begin
            case (funct3)
                Funct3Lb:  load_data = {{24{byte_sel[7]}}, byte_sel};
                Funct3Lh:  load_data = {{16{half[15]}}, half};
                Funct3Lbu: load_data = {24'd0, byte_sel};
                Funct3Lhu: load_data = {16'd0, half};
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: latches one access, runs it on the memory bus and stalls the core.
module load_store_unit
    import rv32i_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    load_store_unit_if.master mem
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        is_store_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        capture;
    logic        in_req;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;

    lsu_align u_align (
        .is_store   (is_store_q),
        .funct3     (funct3_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (wdata_q),
        .mem_rdata  (mem.mem_rdata_i),
        .be         (align_be),
        .mem_wdata  (align_wdata),
        .load_data  (align_rdata)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = lsu_illegal(is_store_i, funct3_i, addr_i[1:0]) ? StErr : StReq;
                end
            end
            StReq: begin
                if (mem.mem_gnt_i) state_d = is_store_q ? StDone : StWait;
            end
            StWait: begin
                if (mem.mem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            is_store_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= addr_i;
                funct3_q   <= funct3_i;
                wdata_q    <= wdata_i;
                is_store_q <= is_store_i;
            end
            if (capture) rdata_q <= align_rdata;
        end
    end

    assign in_req  = (state_q == StReq);
    assign stall_o = ((state_q == StIdle) && req_valid_i) || in_req || (state_q == StWait);
    assign done_o  = (state_q == StDone);
    assign err_o   = (state_q == StErr);
    assign rdata_o = rdata_q;

    // Bus driven only while a request is outstanding; zero everywhere else.
    assign mem.mem_req_o   = in_req;
    assign mem.mem_we_o    = in_req && is_store_q;
    assign mem.mem_be_o    = in_req ? align_be : 4'b0000;
    assign mem.mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.mem_wdata_o = (in_req && is_store_q) ? align_wdata : 32'd0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have these ports: clk_i, input, 1, sole clock, rising edge.
REQ-002 The block SHALL have these ports: rst_ni, input, 1, reset, synchronous, active-low.
REQ-003 The block SHALL have these ports: req_valid_i, input, 1, current instruction is a load or a store.
REQ-004 The block SHALL have these ports: is_store_i, input, 1, 1 means store, 0 means load.
REQ-005 The block SHALL have these ports: funct3_i, input, 3, instruction funct3 giving access size and sign.
REQ-006 The block SHALL have these ports: addr_i, input, 32, effective address (ALU Result_o).
REQ-007 The block SHALL have these ports: wdata_i, input, 32, store data (rs2).
REQ-008 The block SHALL have these ports: stall_o, output, 1, hold PC and register-file write.
REQ-009 The block SHALL have these ports: done_o, output, 1, one-cycle pulse when the access completes.
REQ-010 The block SHALL have these ports: err_o, output, 1, one-cycle pulse on a misaligned access or illegal funct3.
REQ-011 The block SHALL have these ports: rdata_o, output, 32, aligned and extended load result.
REQ-012 The block SHALL have these memory ports: mem_req_o (output, 1), mem_we_o (output, 1), mem_be_o (output, 4), mem_addr_o (output, 32, word-aligned), mem_wdata_o (output, 32).
REQ-013 The block SHALL have these memory ports: mem_gnt_i (input, 1), mem_rvalid_i (input, 1), mem_rdata_i (input, 32).

Function
REQ-014 The block SHALL implement the FSM states IDLE, REQ, WAIT, DONE and ERR.
REQ-015 In IDLE with req_valid_i=1, the block SHALL latch addr_i, funct3_i, wdata_i and is_store_i.
REQ-016 From IDLE with req_valid_i=1, the block SHALL go to ERR if the access is illegal, otherwise to REQ.
REQ-017 An access SHALL be illegal when it is misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0).
REQ-018 An access SHALL be illegal when funct3 is 011, 110 or 111 for a load, or greater than or equal to 011 for a store.
REQ-019 In REQ, mem_req_o SHALL be 1, and mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o SHALL stay stable until mem_gnt_i=1.
REQ-020 In REQ on mem_gnt_i, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-021 mem_rvalid_i is only legal no earlier than the cycle after the grant.
REQ-022 In WAIT on mem_rvalid_i, the block SHALL capture the extracted data into rdata_o and go to DONE.
REQ-023 DONE SHALL assert done_o for one cycle and go to IDLE; req_valid_i SHALL be ignored in DONE.
REQ-024 ERR SHALL assert err_o for one cycle, SHALL issue no memory request and SHALL go to IDLE.
REQ-025 stall_o SHALL equal (IDLE and req_valid_i) or REQ or WAIT; stall_o SHALL be 0 in DONE and ERR.
REQ-026 mem_addr_o SHALL be {addr[31:2], 2'b00}.
REQ-027 Store byte enables SHALL be: SB = 0001<<addr[1:0], SH = 0011<<{addr[1],1'b0}, SW = 1111.
REQ-028 mem_wdata_o SHALL be {4{byte}} for SB, {2{half}} for SH, and the full word for SW.
REQ-029 For loads, mem_we_o SHALL be 0 and mem_be_o SHALL be 1111.
REQ-030 Load extraction SHALL select the byte or half by addr[1:0]; LB and LH SHALL sign-extend, LBU and LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-031 rdata_o SHALL hold its value until the next completed load.
REQ-032 Outside REQ, all mem_* outputs SHALL be 0.
REQ-033 Minimum load latency SHALL be: accept at T, gnt at T+1, rvalid at T+2, done_o at T+3; minimum store latency SHALL be done_o at T+2.

Reset
REQ-034 When rst_ni=0 at a clock edge, the block SHALL go to IDLE and clear all outputs and latched fields to 0, including during REQ or WAIT.
REQ-035 An mem_rvalid_i arriving after a reset SHALL be ignored.

Structure
REQ-036 Load and store funct3 codes and the FSM state enum SHALL live in the shared package rv32i_pkg.
REQ-037 Byte-lane alignment and load extraction SHALL be a combinational sub-module lsu_align.

Verification
REQ-038 SW with addr=0x100 and wdata=0xDEADBEEF, gnt at the first REQ cycle, SHALL give be=1111, addr=0x100, done_o at T+2, and stall_o at T and T+1.
REQ-039 SB with addr=0x203 and wdata=0x000000A5 SHALL give be=1000 and mem_wdata_o=0xA5A5A5A5.
REQ-040 LB with addr=0x102 and mem_rdata_i=0x12F45678 SHALL give rdata_o=0xFFFFFFF4; LHU with addr=0x102 SHALL give rdata_o=0x000012F4.
REQ-041 LW with addr=0x101 SHALL give err_o for one cycle at T+1, mem_req_o=0 throughout, and rdata_o unchanged.
REQ-042 LW with gnt delayed 3 cycles SHALL hold the request stable for those 3 cycles and keep stall_o high until done_o.
REQ-043 rst_ni=0 during WAIT followed by a late rvalid SHALL return the block to IDLE with no done_o and rdata_o=0.
